fmm_reduce_kernel_mul_pipe: RTL and testbench

//  Parametrised pipelined multiplier for the fmm_reduce_kernel datapath.
//  - Per-transaction signed/unsigned mode on each operand.
//  - NUM_STAGE-deep register pipeline with valid/ready flow control.
//  - Optional output saturation instead of truncation.

---
 rtl/fmm_reduce_kernel_mul_pipe_if.sv | 28 ++
 rtl/fmm_reduce_kernel_mul_pipe.sv | 118 +++++++++++
 tb/tb_fmm_reduce_kernel_mul_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmm_reduce_kernel_mul_pipe_if.sv
// Operand/result handshake bundle for the fmm_reduce_kernel multiplier pipe.
interface fmm_reduce_kernel_mul_pipe_if #(
   parameter int unsigned din0_WIDTH = 32,
   parameter int unsigned din1_WIDTH = 31,
   parameter int unsigned dout_WIDTH = 62
);
   logic                  in_valid;
   logic                  in_ready;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  din0_sgn;
   logic                  din1_sgn;
   logic                  out_valid;
   logic                  out_ready;
   logic [dout_WIDTH-1:0] dout;
   logic                  dout_sgn;
   logic                  sat_flag;

   modport master (
      output in_valid, din0, din1, din0_sgn, din1_sgn, out_ready,
      input  in_ready, out_valid, dout, dout_sgn, sat_flag
   );

   modport slave (
      input  in_valid, din0, din1, din0_sgn, din1_sgn, out_ready,
      output in_ready, out_valid, dout, dout_sgn, sat_flag
   );
endinterface

// File: rtl/fmm_reduce_kernel_mul_pipe.sv
// Pipelined signed/unsigned multiplier with global-stall flow control and
// optional output clamping in the final stage.
module fmm_reduce_kernel_mul_pipe #(
   parameter int unsigned NUM_STAGE  = 3,
   parameter int unsigned din0_WIDTH = 32,
   parameter int unsigned din1_WIDTH = 31,
   parameter int unsigned dout_WIDTH = 62,
   parameter int unsigned SATURATE   = 0
) (
   input logic                         ap_clk,
   input logic                         ap_rst_n,
   fmm_reduce_kernel_mul_pipe_if.slave bus
);

   localparam int unsigned P_W = din0_WIDTH + din1_WIDTH + 1;

   logic [NUM_STAGE-1:0]   r_vld;
   logic [dout_WIDTH-1:0]  r_dout;
   logic                   r_dsgn;
   logic                   r_sat;

   logic                   w_adv;
   logic signed [din0_WIDTH:0] w_a_ext;
   logic signed [din1_WIDTH:0] w_b_ext;
   logic signed [P_W-1:0]  w_prod;
   logic                   w_sgn_in;
   logic signed [P_W-1:0]  w_fin_p;
   logic                   w_fin_s;
   logic [dout_WIDTH-1:0]  w_dout;
   logic                   w_sat;
   logic                   w_unused;

   // Whole pipe moves together; a stalled output freezes every stage.
   assign w_adv        = ~r_vld[NUM_STAGE-1] | bus.out_ready;
   assign bus.in_ready = w_adv;

   // One extra bit per operand makes the signed multiply exact for all modes.
   assign w_a_ext  = {bus.din0_sgn & bus.din0[din0_WIDTH-1], bus.din0};
   assign w_b_ext  = {bus.din1_sgn & bus.din1[din1_WIDTH-1], bus.din1};
   assign w_prod   = P_W'(w_a_ext) * P_W'(w_b_ext);
   assign w_sgn_in = bus.din0_sgn | bus.din1_sgn;

   generate
      if (NUM_STAGE == 1) begin : g_direct
         assign w_fin_p = w_prod;
         assign w_fin_s = w_sgn_in;
      end else begin : g_chain
         logic signed [P_W-1:0] r_p [NUM_STAGE-1];
         logic                  r_s [NUM_STAGE-1];

         always_ff @(posedge ap_clk) begin
            if (w_adv) begin
               r_p[0] <= w_prod;
               r_s[0] <= w_sgn_in;
               for (int i = 1; i < NUM_STAGE - 1; i++) begin
                  r_p[i] <= r_p[i-1];
                  r_s[i] <= r_s[i-1];
               end
            end
         end

         assign w_fin_p = r_p[NUM_STAGE-2];
         assign w_fin_s = r_s[NUM_STAGE-2];
      end
   endgenerate

   generate
      if (dout_WIDTH >= P_W) begin : g_ext
         assign w_dout = dout_WIDTH'(w_fin_p);
         assign w_sat  = 1'b0;
      end else if (SATURATE == 0) begin : g_trunc
         assign w_dout = w_fin_p[dout_WIDTH-1:0];
         assign w_sat  = 1'b0;
      end else begin : g_clamp
         // Out of range when the discarded upper bits are not a pure extension.
         always_comb begin
            w_dout = w_fin_p[dout_WIDTH-1:0];
            w_sat  = 1'b0;
            if (w_fin_s) begin
               if (w_fin_p[P_W-1:dout_WIDTH-1] !=
                   {(P_W-dout_WIDTH+1){w_fin_p[P_W-1]}}) begin
                  w_sat  = 1'b1;
                  w_dout = w_fin_p[P_W-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                          : {1'b0, {(dout_WIDTH-1){1'b1}}};
               end
            end else if (w_fin_p[P_W-1:dout_WIDTH] != '0) begin
               w_sat  = 1'b1;
               w_dout = '1;
            end
         end
      end
   endgenerate

   assign w_unused = ^{w_fin_p, w_fin_s};

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_vld  <= '0;
         r_dout <= '0;
         r_dsgn <= 1'b0;
         r_sat  <= 1'b0;
      end else if (w_adv) begin
         r_vld[0] <= bus.in_valid;
         for (int i = 1; i < NUM_STAGE; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
         r_dout <= w_dout;
         r_dsgn <= w_fin_s;
         r_sat  <= w_sat;
      end
   end

   assign bus.out_valid = r_vld[NUM_STAGE-1];
   assign bus.dout      = r_dout;
   assign bus.dout_sgn  = r_dsgn;
   assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_fmm_reduce_kernel_mul_pipe.sv
// Scoreboard bench: three builds (default, 1-stage 8x8->17, 8-stage saturating 10x10->16).
module tb_fmm_reduce_kernel_mul_pipe;

   typedef struct {
      logic [127:0] d;
      logic         s;
      logic         f;
      int           c;
      bit           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_bc;
   int   cyc;
   int   n_chk;
   int   n_fail;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t none;

   int WA  [3] = '{32, 8, 10};
   int WB  [3] = '{31, 8, 10};
   int DWS [3] = '{62, 17, 16};
   int SATP[3] = '{0, 0, 1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fmm_reduce_kernel_mul_pipe_if #(.din0_WIDTH(32), .din1_WIDTH(31), .dout_WIDTH(62)) ia ();
   fmm_reduce_kernel_mul_pipe_if #(.din0_WIDTH(8),  .din1_WIDTH(8),  .dout_WIDTH(17)) ib ();
   fmm_reduce_kernel_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(10), .dout_WIDTH(16)) ic ();

   fmm_reduce_kernel_mul_pipe #(.NUM_STAGE(3), .din0_WIDTH(32), .din1_WIDTH(31),
      .dout_WIDTH(62), .SATURATE(0)) dut_a (.ap_clk(clk), .ap_rst_n(rst_a), .bus(ia));
   fmm_reduce_kernel_mul_pipe #(.NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(8),
      .dout_WIDTH(17), .SATURATE(0)) dut_b (.ap_clk(clk), .ap_rst_n(rst_bc), .bus(ib));
   fmm_reduce_kernel_mul_pipe #(.NUM_STAGE(8), .din0_WIDTH(10), .din1_WIDTH(10),
      .dout_WIDTH(16), .SATURATE(1)) dut_c (.ap_clk(clk), .ap_rst_n(rst_bc), .bus(ic));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Mathematical product of the operand values, then clamp or wrap to dw bits.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sa, input logic sb,
                                  input int wa, input int wb, input int dw, input bit sat);
      exp_t e;
      logic signed [127:0] av, bv, p, lo, hi, one;
      one = 128'sd1;
      av = $signed(128'(a));
      bv = $signed(128'(b));
      if (sa && a[wa-1]) av = av - (one <<< wa);
      if (sb && b[wb-1]) bv = bv - (one <<< wb);
      p = av * bv;
      if (sa || sb) begin
         lo = -(one <<< (dw - 1));
         hi = (one <<< (dw - 1)) - one;
      end else begin
         lo = '0;
         hi = (one <<< dw) - one;
      end
      e.f = 1'b0;
      if (sat && p > hi) begin
         p = hi; e.f = 1'b1;
      end else if (sat && p < lo) begin
         p = lo; e.f = 1'b1;
      end
      e.d   = 128'(p & ((one <<< dw) - one));
      e.s   = sa | sb;
      e.c   = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [127:0] d, input logic s, input logic f);
      exp_t e;
      e.d = d; e.s = s; e.f = f; e.c = 0; e.lat = 1'b0;
      return e;
   endfunction

   task automatic cmp(input string nm, input exp_t e, input logic [127:0] d,
                      input logic s, input logic f, input int n);
      chk({nm, " dout"}, d, e.d);
      chk({nm, " dout_sgn"}, 128'(s), 128'(e.s));
      chk({nm, " sat_flag"}, 128'(f), 128'(e.f));
      if (e.lat) chk({nm, " latency"}, 128'(cyc - e.c), 128'(n));
   endtask

   function automatic int qsize(input int sel);
      case (sel)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   task automatic drive(input int sel, input bit v, input logic [63:0] a, input logic [63:0] b,
                        input logic sa, input logic sb, input bit ordy, input bit lat,
                        input bit use_exp, input exp_t de, output bit acc);
      logic [63:0] am, bm;
      exp_t e;
      am = a & ((64'd1 << WA[sel]) - 64'd1);
      bm = b & ((64'd1 << WB[sel]) - 64'd1);
      case (sel)
         0: begin
            ia.in_valid = v; ia.din0 = am[31:0]; ia.din1 = bm[30:0];
            ia.din0_sgn = sa; ia.din1_sgn = sb; ia.out_ready = ordy;
         end
         1: begin
            ib.in_valid = v; ib.din0 = am[7:0]; ib.din1 = bm[7:0];
            ib.din0_sgn = sa; ib.din1_sgn = sb; ib.out_ready = ordy;
         end
         default: begin
            ic.in_valid = v; ic.din0 = am[9:0]; ic.din1 = bm[9:0];
            ic.din0_sgn = sa; ic.din1_sgn = sb; ic.out_ready = ordy;
         end
      endcase
      @(negedge clk);
      case (sel)
         0:       acc = v && ia.in_ready;
         1:       acc = v && ib.in_ready;
         default: acc = v && ic.in_ready;
      endcase
      if (acc) begin
         e = use_exp ? de : model(am, bm, sa, sb, WA[sel], WB[sel], DWS[sel], SATP[sel] != 0);
         e.c   = cyc;
         e.lat = lat;
         case (sel)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int sel, input bit ordy);
      bit acc;
      drive(sel, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, ordy, 1'b0, 1'b0, none, acc);
   endtask

   task automatic dir(input int sel, input logic [63:0] a, input logic [63:0] b,
                      input logic sa, input logic sb, input exp_t de);
      bit acc;
      drive(sel, 1'b1, a, b, sa, sb, 1'b1, 1'b1, 1'b1, de, acc);
      chk("directed accept", 128'(acc), 128'(1));
   endtask

   task automatic drain(input int sel);
      for (int i = 0; i < 30; i++) begin
         if (qsize(sel) == 0) break;
         idle(sel, 1'b1);
      end
      chk("drain", 128'(qsize(sel)), 128'(0));
   endtask

   // Monitor A: scoreboard pop, stall stability and ready rule.
   bit                 a_stall;
   logic [61:0]        pa_d;
   logic               pa_s, pa_f;
   always @(negedge clk) begin
      if (rst_a) begin
         chk("a in_ready", 128'(ia.in_ready), 128'(!ia.out_valid || ia.out_ready));
         if (a_stall) begin
            chk("a hold valid", 128'(ia.out_valid), 128'(1));
            chk("a hold dout", 128'(ia.dout), 128'(pa_d));
            chk("a hold sgn", 128'(ia.dout_sgn), 128'(pa_s));
            chk("a hold sat", 128'(ia.sat_flag), 128'(pa_f));
         end
         if (ia.out_valid && ia.out_ready) begin
            chk("a queue", 128'(qa.size() != 0), 128'(1));
            if (qa.size() != 0) cmp("a", qa.pop_front(), 128'(ia.dout), ia.dout_sgn, ia.sat_flag, 3);
         end
         a_stall = ia.out_valid && !ia.out_ready;
         pa_d = ia.dout; pa_s = ia.dout_sgn; pa_f = ia.sat_flag;
      end else begin
         a_stall = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_bc && ib.out_valid && ib.out_ready) begin
         chk("b queue", 128'(qb.size() != 0), 128'(1));
         if (qb.size() != 0) cmp("b", qb.pop_front(), 128'(ib.dout), ib.dout_sgn, ib.sat_flag, 1);
      end
      if (rst_bc && ic.out_valid && ic.out_ready) begin
         chk("c queue", 128'(qc.size() != 0), 128'(1));
         if (qc.size() != 0) cmp("c", qc.pop_front(), 128'(ic.dout), ic.dout_sgn, ic.sat_flag, 8);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit acc;
      int cnt;
      none = mk(128'd0, 1'b0, 1'b0);
      rst_a = 1'b0; rst_bc = 1'b0;
      ia.in_valid = 1'b0; ia.din0 = '0; ia.din1 = '0; ia.din0_sgn = 1'b0; ia.din1_sgn = 1'b0; ia.out_ready = 1'b1;
      ib.in_valid = 1'b0; ib.din0 = '0; ib.din1 = '0; ib.din0_sgn = 1'b0; ib.din1_sgn = 1'b0; ib.out_ready = 1'b1;
      ic.in_valid = 1'b0; ic.din0 = '0; ic.din1 = '0; ic.din0_sgn = 1'b0; ic.din1_sgn = 1'b0; ic.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b1; rst_bc = 1'b1;
      @(negedge clk);
      chk("rst out_valid", 128'(ia.out_valid), 128'(0));
      chk("rst dout", 128'(ia.dout), 128'(0));
      chk("rst dout_sgn", 128'(ia.dout_sgn), 128'(0));
      chk("rst sat_flag", 128'(ia.sat_flag), 128'(0));
      chk("rst in_ready", 128'(ia.in_ready), 128'(1));
      chk("rst b out_valid", 128'(ib.out_valid), 128'(0));
      chk("rst c out_valid", 128'(ic.out_valid), 128'(0));
      @(posedge clk);
      #1;

      // Default build: directed corner products, then a stalled random stream.
      dir(0, 64'hFFFF_FFFF, 64'h7FFF_FFFF, 1'b1, 1'b0, mk(128'h3FFF_FFFF_8000_0001, 1'b1, 1'b0));
      dir(0, 64'h0000_0003, 64'h0000_0005, 1'b0, 1'b0, mk(128'd15, 1'b0, 1'b0));
      dir(0, 64'hFFFF_FFFF, 64'h7FFF_FFFF, 1'b1, 1'b1, mk(128'd1, 1'b1, 1'b0));
      drive(0, 1'b1, 64'hFFFF_FFFF, 64'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, none, acc);
      drive(0, 1'b1, 64'h8000_0000, 64'h4000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, none, acc);
      drain(0);

      cnt = 0;
      for (int i = 0; i < 400 && cnt < 40; i++) begin
         drive(0, $urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2) != 0, 1'b0, 1'b0, none, acc);
         if (acc) cnt++;
      end
      chk("a random beats accepted", 128'(cnt), 128'(40));
      drain(0);

      // Fill with a stalled output, then reset: none of these beats may emerge.
      for (int i = 0; i < 3; i++)
         drive(0, 1'b1, 64'(i + 7), 64'(i + 9), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, none, acc);
      rst_a = 1'b0;
      ia.in_valid = 1'b0;
      @(posedge clk);
      #1;
      qa.delete();
      rst_a = 1'b1;
      @(negedge clk);
      chk("a post-reset out_valid", 128'(ia.out_valid), 128'(0));
      @(posedge clk);
      #1;
      repeat (10) idle(0, 1'b1);
      dir(0, 64'd12345, 64'd678, 1'b0, 1'b0, mk(128'd8369910, 1'b0, 1'b0));
      drain(0);

      // One-stage 8x8->17 build: mode sweep, then back-to-back random beats.
      dir(1, 64'hFF, 64'hFF, 1'b0, 1'b0, mk(128'd65025, 1'b0, 1'b0));
      dir(1, 64'hFF, 64'hFF, 1'b0, 1'b1, mk(128'h1FF01, 1'b1, 1'b0));
      dir(1, 64'hFF, 64'hFF, 1'b1, 1'b0, mk(128'h1FF01, 1'b1, 1'b0));
      dir(1, 64'hFF, 64'hFF, 1'b1, 1'b1, mk(128'h00001, 1'b1, 1'b0));
      for (int i = 0; i < 30; i++) begin
         drive(1, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, none, acc);
         chk("b continuous accept", 128'(acc), 128'(1));
      end
      drain(1);

      // Eight-stage saturating 10x10->16 build.
      dir(2, 64'd300, 64'd300, 1'b1, 1'b1, mk(128'h7FFF, 1'b1, 1'b1));
      dir(2, 64'd200, 64'd400, 1'b0, 1'b0, mk(128'hFFFF, 1'b0, 1'b1));
      dir(2, 64'd724, 64'd300, 1'b1, 1'b1, mk(128'h8000, 1'b1, 1'b1));
      dir(2, 64'd100, 64'd1021, 1'b1, 1'b1, mk(128'hFED4, 1'b1, 1'b0));
      dir(2, 64'h3FF, 64'd1023, 1'b1, 1'b0, mk(128'hFC01, 1'b1, 1'b0));
      for (int i = 0; i < 30; i++) begin
         drive(2, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, none, acc);
         chk("c continuous accept", 128'(acc), 128'(1));
      end
      drain(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
